// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [1:0]  fault;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with push, pop, clear, count, full and empty.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ifetch_resp.sv
// Fetch responder: one memory read at a time, timeout, result FIFO, flush.
// Optional IFETCH_MISALIGN_CHK_EN faults misaligned requests without a read.
module ifetch_resp
  import ifetch_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  input  logic        flush_i,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic [1:0]  inst_fault_o,
  input  logic        inst_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e       state_q;
  logic         mem_rd_q;
  logic [31:0]  mem_addr_q;
  logic [31:0]  req_addr_q;
  logic [7:0]   tmo_q;

  logic         accept;
  logic         misalign;
  logic         tmo_hit;
  logic         push_c;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;

  assign req_ready_o = (state_q == ST_IDLE) & ~flush_i &
                       (int'(fifo_count) < FIFO_DEPTH);
  assign accept  = req_valid_i & req_ready_o;
  assign tmo_hit = (tmo_q == TMO_LAST);

`ifdef IFETCH_MISALIGN_CHK_EN
  assign misalign = |req_addr_i[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    push_c     = 1'b0;
    push_entry = '{addr: req_addr_q, inst: mem_rdata_i, fault: FAULT_NONE};
    if (state_q == ST_WAIT && !flush_i) begin
      if (mem_ack_i) begin
        push_c = 1'b1;
      end else if (tmo_hit) begin
        push_c           = 1'b1;
        push_entry.inst  = NOP_INST;
        push_entry.fault = FAULT_TIMEOUT;
      end
    end
    if (state_q == ST_IDLE && accept && misalign) begin
      push_c     = 1'b1;
      push_entry = '{addr: req_addr_i, inst: NOP_INST, fault: FAULT_MISALIGN};
    end
  end

  // WAIT and DROP share completion; only WAIT produces a result.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q    <= ST_IDLE;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      req_addr_q <= '0;
      tmo_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept && !misalign) begin
            mem_addr_q <= word_addr(req_addr_i);
            req_addr_q <= req_addr_i;
            mem_rd_q   <= 1'b1;
            tmo_q      <= '0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT, ST_DROP: begin
          if (mem_ack_i || tmo_hit) begin
            mem_rd_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
            if (flush_i) state_q <= ST_DROP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_pop = inst_valid_o & inst_ready_i;

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_sys_i),
    .rst_i   (rst_sys_i),
    .clr_i   (flush_i),
    .push_i  (push_c & ~fifo_full),
    .din_i   (push_entry),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head         = fifo_dout;
  assign inst_valid_o = ~fifo_empty;
  assign inst_o       = inst_valid_o ? head.inst  : '0;
  assign inst_addr_o  = inst_valid_o ? head.addr  : '0;
  assign inst_fault_o = inst_valid_o ? head.fault : '0;
  assign mem_rd_o     = mem_rd_q;
  assign mem_addr_o   = mem_addr_q;

endmodule

// File: tb/tb_ifetch_resp.sv
// Scoreboard bench for ifetch_resp with a transaction-level fetch model.
module tb_ifetch_resp;

  localparam int DEPTH = 2;
  localparam int TMO   = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [1:0]  fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_sys_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic        req_ready_o;
  logic        flush_i = 1'b0;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [1:0]  inst_fault_o;
  logic        inst_ready_i = 1'b0;

  ifetch_resp #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_sys_i    (clk),
    .rst_sys_i    (rst_sys_i),
    .req_valid_i  (req_valid_i),
    .req_addr_i   (req_addr_i),
    .req_ready_o  (req_ready_o),
    .flush_i      (flush_i),
    .mem_rd_o     (mem_rd_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_fault_o (inst_fault_o),
    .inst_ready_i (inst_ready_i)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  exp_t exp_q[$];

  // One outstanding fetch: accept cycle, memory delay, data, flush mark.
  bit          infl = 0;
  bit          flushed = 0;
  int          acc_cyc = 0;
  int          dly = 0;
  logic [31:0] f_addr = '0;
  logic [31:0] f_data = '0;
  int          next_dly = 0;
  logic [31:0] next_data = '0;
  bit          last_acc = 0;
  bit          last_ready = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input bit v, input logic [31:0] a, input bit fl,
                       input bit rdy, input bit rs);
    int lim;
    bit mis;
    rst_sys_i    = rs;
    req_valid_i  = v;
    req_addr_i   = a;
    flush_i      = fl;
    inst_ready_i = rdy;
    mem_ack_i    = !rs && infl && (cyc == acc_cyc + dly);
    mem_rdata_i  = mem_ack_i ? f_data : $urandom();
    #8;
    last_ready = req_ready_o;
    last_acc   = 0;
    if (rs) begin
      exp_q.delete();
      infl = 0;
    end else begin
      chk("mem_rd", 64'(mem_rd_o), 64'(infl));
      if (infl) chk("mem_addr", 64'(mem_addr_o), 64'({f_addr[31:2], 2'b00}));
      if (infl || fl) chk("req_ready_busy", 64'(req_ready_o), 64'd0);
      if (fl) begin
        exp_q.delete();
        if (infl) flushed = 1;
      end
      lim = (dly < TMO) ? dly : TMO;
      if (infl && cyc == acc_cyc + lim) begin
        infl = 0;
        if (!flushed) begin
          if (dly <= TMO) exp_q.push_back('{addr: f_addr, inst: f_data, fault: 2'b00});
          else            exp_q.push_back('{addr: f_addr, inst: NOP, fault: 2'b01});
        end
      end
      if (v && req_ready_o) begin
        last_acc = 1;
`ifdef IFETCH_MISALIGN_CHK_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 0;
`endif
        if (mis) begin
          exp_q.push_back('{addr: a, inst: NOP, fault: 2'b10});
        end else begin
          infl    = 1;
          flushed = 0;
          acc_cyc = cyc;
          dly     = (next_dly != 0) ? next_dly : int'($urandom_range(1, TMO + 2));
          f_data  = next_data;
          f_addr  = a;
        end
        next_dly = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fetch(input logic [31:0] a, input int d,
                       input logic [31:0] data, input bit rdy);
    int n = 0;
    next_dly  = d;
    next_data = data;
    do begin
      cycle(1, a, 0, rdy, 0);
      n++;
    end while (!last_acc && n < 40);
    if (!last_acc) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no accept want accept of %h", a);
    end
  endtask

  task automatic settle(input bit rdy);
    int n = 0;
    while (infl && n < 40) begin
      cycle(0, 0, 0, rdy, 0);
      n++;
    end
    chk("settle", 64'(infl), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((infl || exp_q.size() != 0) && n < 80) begin
      cycle(0, 0, 0, 1, 0);
      n++;
    end
    cycle(0, 0, 0, 1, 0);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", 64'(inst_valid_o), 64'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"},  64'(req_ready_o),  64'd1);
    chk({tag, "_mem_rd"}, 64'(mem_rd_o),     64'd0);
    chk({tag, "_maddr"},  64'(mem_addr_o),   64'd0);
    chk({tag, "_valid"},  64'(inst_valid_o), 64'd0);
    chk({tag, "_inst"},   64'(inst_o),       64'd0);
    chk({tag, "_iaddr"},  64'(inst_addr_o),  64'd0);
    chk({tag, "_fault"},  64'(inst_fault_o), 64'd0);
  endtask

  // Monitor: compare every consumed head against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_sys_i) begin
        if (exp_q.size() == 0) begin
          chk("valid_when_empty", 64'(inst_valid_o), 64'd0);
        end else if (inst_valid_o && inst_ready_i) begin
          e = exp_q.pop_front();
          chk("inst_addr",  64'(inst_addr_o),  64'(e.addr));
          chk("inst",       64'(inst_o),       64'(e.inst));
          chk("inst_fault", 64'(inst_fault_o), 64'(e.fault));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk_reset_outs("rst");

    next_dly  = 1;
    next_data = 32'h0050_0093;
    cycle(1, 32'h100, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("zw_valid", 64'(inst_valid_o), 64'd1);
    chk("zw_inst",  64'(inst_o),       64'h0050_0093);
    chk("zw_addr",  64'(inst_addr_o),  64'h100);
    chk("zw_fault", 64'(inst_fault_o), 64'd0);
    cycle(0, 0, 0, 1, 0);

    fetch(32'h0, 1, 32'h1111_0001, 0);
    settle(0);
    fetch(32'h4, 1, 32'h2222_0002, 0);
    settle(0);
    repeat (3) begin
      cycle(1, 32'h8, 0, 0, 0);
      chk("bp_stall", 64'(last_ready), 64'd0);
    end
    cycle(1, 32'h8, 0, 1, 0);
    chk("bp_stall_pop", 64'(last_ready), 64'd0);
    fetch(32'h8, 1, 32'h3333_0003, 0);
    settle(0);
    drain();

    fetch(32'h300, TMO + 3, 32'hdead_beef, 0);
    repeat (TMO) cycle(0, 0, 0, 0, 0);
    chk("tmo_valid",  64'(inst_valid_o), 64'd1);
    chk("tmo_inst",   64'(inst_o),       64'(NOP));
    chk("tmo_fault",  64'(inst_fault_o), 64'd1);
    chk("tmo_mem_rd", 64'(mem_rd_o),     64'd0);
    drain();

    fetch(32'h400, 4, 32'h4444_0004, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("fl_idle",  64'(req_ready_o),  64'd1);
    chk("fl_valid", 64'(inst_valid_o), 64'd0);
    fetch(32'h200, 1, 32'h5555_0005, 0);
    settle(0);
    drain();

    fetch(32'h102, 1, 32'h6666_0006, 0);
    settle(0);
    drain();

    fetch(32'h500, 1, 32'h7777_0007, 0);
    settle(0);
    fetch(32'h600, TMO + 3, 32'h8888_0008, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk_reset_outs("rst_mid");

    repeat (400) begin
      a = $urandom() & 32'hffff_fffc;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      next_dly  = int'($urandom_range(1, TMO + 2));
      next_data = $urandom();
      cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0, 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch_resp.md
# ifetch_resp

Instruction-fetch responder at the far end of the program-counter address interface. It accepts fetch addresses from the PC stage via a valid/ready handshake and runs one instruction-memory read at a time, with a bounded wait and timeout. Results are buffered in a small FIFO and presented to decode as instruction, address and fault code. A flush input discards all buffered and in-flight fetches on a jump.

## Interface
- FIFO_DEPTH, 2 — result buffer entries; power of two, at least 2.
- TIMEOUT_CYC, 16 — maximum cycles in WAIT before a timeout fault; range 2..255.
- clk_sys_i  in  1  — system clock; all logic on the rising edge.
- rst_sys_i  in  1  — reset, synchronous and active-high.
- req_valid_i  in  1  — PC stage presents a fetch address.
- req_addr_i  in  32  — fetch address.
- req_ready_o  out  1  — responder accepts the request this cycle.
- flush_i  in  1  — drop all buffered and in-flight fetches.
- mem_rd_o  out  1  — memory read strobe; held until ack or timeout.
- mem_addr_o  out  32  — memory word address.
- mem_rdata_i  in  32  — read data; valid when mem_ack_i is high.
- mem_ack_i  in  1  — read completes this cycle.
- inst_valid_o  out  1  — FIFO head is valid.
- inst_o  out  32  — instruction word.
- inst_addr_o  out  32  — address the instruction was fetched from.
- inst_fault_o  out  2  — fault code: 00 none, 01 timeout, 10 misaligned.
- inst_ready_i  in  1  — decode consumes the FIFO head.

## Operation
- FSM states: IDLE, WAIT, DROP.
- req_ready_o = (state==IDLE) & !flush_i & (occupancy < FIFO_DEPTH). The signal is combinational.
- Accept in IDLE: register mem_addr_o <= {req_addr_i[31:2],2'b00}, mem_rd_o <= 1, clear the timeout counter, go to WAIT. The full request address is also latched for inst_addr_o.
- WAIT, mem_ack_i=1: push {addr, mem_rdata_i, 00}, mem_rd_o <= 0, go to IDLE.
- WAIT, no ack, counter == TIMEOUT_CYC-1: push {addr, NOP, 01}, mem_rd_o <= 0, go to IDLE. Otherwise the counter increments.
- flush_i: the FIFO empties at the next edge. If the state is WAIT, go to DROP with mem_rd_o still held. Any result from that cycle is discarded, including an ack in the same cycle.
- DROP: wait for ack or timeout, push nothing, then mem_rd_o <= 0 and go to IDLE. A flush while in DROP keeps the state in DROP.
- Pop when inst_valid_o & inst_ready_i. A push and a pop in the same cycle leave occupancy unchanged.
- Overflow is impossible because a request is accepted only when occupancy < FIFO_DEPTH. Occupancy is the FIFO count only, since at most one fetch is outstanding and a push happens only after acceptance.
- The FIFO read and write pointers wrap modulo FIFO_DEPTH.
- Reset values: state IDLE, mem_rd_o 0, mem_addr_o 0, FIFO empty, inst_valid_o 0, inst_o 0, inst_addr_o 0, inst_fault_o 0, timeout counter 0. After reset, req_ready_o is 1.

## Timing
- Accept at cycle N → mem_rd_o high at N+1.
- Ack at cycle M ≥ N+1 → inst_valid_o high at M+1, so a zero-wait memory gives valid at N+2.
- Throughput is one fetch per 2 cycles with a zero-wait memory.
- Timeout: no ack in cycles N+1..N+TIMEOUT_CYC → fault entry valid at N+TIMEOUT_CYC+1.
- flush_i at cycle F → inst_valid_o low at F+1. req_ready_o is low at F and while in DROP.
- Reset asserted mid-WAIT → mem_rd_o low at the next edge; the pending fetch is abandoned.

## Configuration
- IFETCH_MISALIGN_CHK_EN defined:
  - An accepted request with req_addr_i[1:0] != 0 issues no memory read.
  - It pushes {addr, NOP, 10} at the next edge, and the state stays IDLE.
- Not defined:
  - The low two bits are ignored for the memory access, and fault code 10 is never produced.
  - inst_addr_o still reports the full request address.

## Structure
- Package ifetch_pkg holds:
  - the FSM state enum;
  - the fault-code constants FAULT_NONE, FAULT_TIMEOUT, FAULT_MISALIGN;
  - NOP_INST = 32'h0000_0013;
  - the FIFO entry struct {addr, inst, fault}.
- One sub-module, ifetch_fifo: a synchronous FIFO with push, pop, clear, count, full and empty, parameterised by depth and width.

## Test plan
- Zero-wait memory:
  - Stimulus: req at 0x0000_0100 accepted at cycle 0, ack at cycle 1 with 0x0050_0093.
  - Required: at cycle 2, inst_valid_o=1, inst_o=0x0050_0093, inst_addr_o=0x100, fault 00.
- Backpressure:
  - Stimulus: FIFO_DEPTH=2, inst_ready_i=0, fetches to 0x0, 0x4, 0x8.
  - Required: the third request stalls with req_ready_o=0 until one pop occurs, and no entry is lost.
- Timeout:
  - Stimulus: TIMEOUT_CYC=4, mem_ack_i never asserted.
  - Required: the entry is NOP with fault 01 at accept+5, and mem_rd_o is low from then on.
- Flush mid-WAIT:
  - Stimulus: flush at accept+2, ack at accept+4.
  - Required: no entry is pushed, the state returns to IDLE at accept+5, and the next request to 0x200 is fetched normally.
- Misalign (IFETCH_MISALIGN_CHK_EN defined):
  - Stimulus: req at 0x102.
  - Required: mem_rd_o never asserts, and the entry is {0x102, NOP, 10}.
  - Without the macro, the same request drives mem_addr_o=0x100 and the entry has fault 00.
- Reset mid-fetch:
  - Stimulus: rst_sys_i during WAIT with a FIFO entry buffered.
  - Required: all outputs take their reset values at the next edge.
